pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Owns the architectural PC register and the N/Z/V flag register.
- Consumes the branch-target PC produced by the EX-stage branch calculator and decides, each cycle, whether the PC advances or redirects.
- Evaluates the branch condition against the latched flags, handles halt and stall, and keeps performance counters.
- Sits between EX (target/flags producers) and IF (instruction memory address).

Parameters:
- PC_W, 16, PC and target width
- CNT_W, 16, width of the cycle and taken-branch counters

Ports:
- clk, input, 1, system clock
- rst_n, input, 1, asynchronous active-low reset
- instr, input, 16, current instruction; [15:12] opcode, [11:9] condition code
- br_pc, input, PC_W, branch target from the EX branch calculator; only meaningful when opcode==4'b1100
- flags_we, input, 1, latch new flags this cycle
- alu_flags, input, 3, {N,Z,V} from the ALU
- stall, input, 1, hold PC this cycle
- pc, output, PC_W, current PC (registered)
- pc_plus1, output, PC_W, pc+1 (combinational)
- br_taken, output, 1, registered pulse: the previous cycle redirected
- halted, output, 1, registered; high in HALT state
- flags, output, 3, registered {N,Z,V}
- cycle_cnt, output, CNT_W, cycles spent in RUN state, saturating
- taken_cnt, output, CNT_W, branches taken, saturating

Behaviour:
- Reset (async, rst_n low):
  - pc=0x0000, flags=3'b000, br_taken=0, halted=0, both counters=0, state=RUN.
  - Reset asserted mid-operation, including in HALT, forces all of the above immediately.
- States: RUN, HALT.
  - RUN->HALT when opcode==4'b1111 and stall==0. PC is not incremented on that edge.
  - HALT->RUN only via reset.
  - In HALT: pc, flags and counters hold; br_taken=0; halted=1.
- Condition evaluation (RUN, opcode==4'b1100), on cc=instr[11:9] using the registered flags:
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GTE: Z | !N
  - 101 LTE: N | Z
  - 110 OVFL: V
  - 111 UNCOND: 1
- Next PC in RUN, on each rising edge:
  - stall=1: pc holds; no flag update; br_taken<=0; cycle_cnt still increments.
  - Else if branch and condition true: pc<=br_pc; br_taken<=1; taken_cnt increments.
  - Else: pc<=pc+1, wrapping 0xFFFF->0x0000; br_taken<=0.
- Flag updates and branch timing:
  - Flags update on an edge with flags_we=1 and stall=0, in RUN only.
  - A branch in the same cycle as flags_we uses the OLD flags. There is no forwarding.
- Width and arithmetic:
  - pc+1 is computed modulo 2^PC_W.
  - br_pc is used verbatim, with no re-extension here.
  - Counters saturate at all-ones and never wrap.
- br_pc is ignored whenever opcode!=4'b1100. X on br_pc in that case must not propagate to pc.
- Latency: redirect is visible on pc one cycle after the branch instruction is presented. The bubble is owned by IF.

Decomposition:
- Shared package (cpu_pkg):
  - opcode constants OP_B=4'b1100, OP_HLT=4'b1111
  - condition-code constants CC_NE..CC_UNCOND
  - flag bit indices FLAG_N=2, FLAG_Z=1, FLAG_V=0
  - state enum {RUN, HALT}
- One sub-module, br_cond_eval: pure combinational (cc, flags) -> take.
- Counters, state machine and PC register stay in pc_sequencer.

Test Plan:
- Reset then 3 cycles of non-branch instr (0x0000), no stall -> pc 0x0000, 0x0001, 0x0002, 0x0003; cycle_cnt=3; halted=0.
- flags_we with alu_flags=3'b010 (Z), next cycle instr=0xC200 (EQ), br_pc=0x0040, pc=0x0005 -> pc=0x0040, br_taken=1 for one cycle, taken_cnt=1. Repeat with instr=0xC000 (NE) -> pc=0x0041, br_taken=0.
- Same cycle: flags_we with Z=1 and instr=0xC200, old Z=0, br_pc=0x0080, pc=0x0010 -> not taken, pc=0x0011; flags=3'b010 afterwards.
- stall=1 for 2 cycles with instr=0xCE00 (UNCOND), br_pc=0x1234 -> pc holds 2 cycles; cycle_cnt +2; on release pc=0x1234.
- pc=0xFFFF, non-branch -> pc=0x0000. instr=0xF000 -> halted=1 next cycle and pc frozen for 10 cycles regardless of instr/flags_we. Async rst_n pulse mid-cycle -> pc=0x0000 and halted=0 immediately.
- Force taken_cnt to 0xFFFF via repeated UNCOND branches (or a CNT_W=4 build: 16 branches) -> counter stays 0xF/0xFFFF. Opcode 0x0 with br_pc=X -> pc=pc+1, no X.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcodes, condition codes, flag bit positions and
// the PC sequencer state encoding.
package cpu_pkg;

  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [2:0] CC_NE     = 3'b000;
  localparam logic [2:0] CC_EQ     = 3'b001;
  localparam logic [2:0] CC_GT     = 3'b010;
  localparam logic [2:0] CC_LT     = 3'b011;
  localparam logic [2:0] CC_GTE    = 3'b100;
  localparam logic [2:0] CC_LTE    = 3'b101;
  localparam logic [2:0] CC_OVFL   = 3'b110;
  localparam logic [2:0] CC_UNCOND = 3'b111;

  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } seq_state_e;

endpackage

// File: rtl/br_cond_eval.sv
// Branch condition evaluator: maps a condition code and the {N,Z,V} flags
// to a take/no-take decision. Purely combinational.
module br_cond_eval
  import cpu_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [2:0] flags,
  output logic       take
);

  logic n_s;
  logic z_s;
  logic v_s;

  assign n_s = flags[FLAG_N];
  assign z_s = flags[FLAG_Z];
  assign v_s = flags[FLAG_V];

  // Condition decode
  always_comb begin
    take = 1'b0;
    case (cc)
      CC_NE:     take = ~z_s;
      CC_EQ:     take = z_s;
      CC_GT:     take = ~z_s & ~n_s;
      CC_LT:     take = n_s;
      CC_GTE:    take = z_s | ~n_s;
      CC_LTE:    take = n_s | z_s;
      CC_OVFL:   take = v_s;
      CC_UNCOND: take = 1'b1;
      default:   take = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC and flag register owner: advances or redirects the PC
// each cycle, handles stall and halt, and keeps saturating perf counters.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W  = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      instr,
  input  logic [PC_W-1:0]  br_pc,
  input  logic             flags_we,
  input  logic [2:0]       alu_flags,
  input  logic             stall,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_plus1,
  output logic             br_taken,
  output logic             halted,
  output logic [2:0]       flags,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  seq_state_e       state_r;
  seq_state_e       next_state_s;
  logic [PC_W-1:0]  pc_r;
  logic [PC_W-1:0]  pc_next_s;
  logic [PC_W-1:0]  pc_plus1_s;
  logic [2:0]       flags_r;
  logic [2:0]       flags_next_s;
  logic             br_taken_r;
  logic             br_taken_next_s;
  logic             halted_r;
  logic [CNT_W-1:0] cycle_cnt_r;
  logic [CNT_W-1:0] taken_cnt_r;
  logic             cyc_inc_s;
  logic             taken_inc_s;
  logic             is_b_s;
  logic             is_hlt_s;
  logic             take_s;
  logic             instr_unused_s;

  assign is_b_s         = (instr[15:12] == OP_B);
  assign is_hlt_s       = (instr[15:12] == OP_HLT);
  assign pc_plus1_s     = pc_r + PC_ONE;
  assign instr_unused_s = ^instr[8:0];

  // Condition uses the registered flags only; same-cycle flag writes are not forwarded
  br_cond_eval u_br_cond_eval (
    .cc    (instr[11:9]),
    .flags (flags_r),
    .take  (take_s)
  );

  // Next-state, next-PC and next-flag selection
  always_comb begin
    next_state_s    = state_r;
    pc_next_s       = pc_r;
    flags_next_s    = flags_r;
    br_taken_next_s = 1'b0;
    cyc_inc_s       = 1'b0;
    taken_inc_s     = 1'b0;
    case (state_r)
      RUN: begin
        cyc_inc_s = 1'b1;
        if (stall) begin
          pc_next_s = pc_r;
        end else if (is_hlt_s) begin
          next_state_s = HALT;
        end else if (is_b_s && take_s) begin
          // br_pc is only selected on a real taken branch, so X elsewhere never reaches pc
          pc_next_s       = br_pc;
          br_taken_next_s = 1'b1;
          taken_inc_s     = 1'b1;
        end else begin
          pc_next_s = pc_plus1_s;
        end
        if (flags_we && !stall) begin
          flags_next_s = alu_flags;
        end else begin
          flags_next_s = flags_r;
        end
      end
      HALT: begin
        next_state_s = HALT;
      end
      default: begin
        next_state_s = RUN;
      end
    endcase
  end

  // State, PC, flag and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= RUN;
      pc_r       <= {PC_W{1'b0}};
      flags_r    <= 3'b000;
      br_taken_r <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      pc_r       <= pc_next_s;
      flags_r    <= flags_next_s;
      br_taken_r <= br_taken_next_s;
      halted_r   <= (next_state_s == HALT);
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_r <= {CNT_W{1'b0}};
      taken_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (cyc_inc_s && (cycle_cnt_r != CNT_MAX)) begin
        cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
      end
      if (taken_inc_s && (taken_cnt_r != CNT_MAX)) begin
        taken_cnt_r <= taken_cnt_r + CNT_ONE;
      end
    end
  end

  assign pc        = pc_r;
  assign pc_plus1  = pc_plus1_s;
  assign br_taken  = br_taken_r;
  assign halted    = halted_r;
  assign flags     = flags_r;
  assign cycle_cnt = cycle_cnt_r;
  assign taken_cnt = taken_cnt_r;

endmodule
